spi_reg_target: RTL

SPI target (slave) that terminates the host SPI link inside the chip and converts each frame into one register-bus write or read. It sits between the pad-level SPI pins and the register file of `reversible_pe`. It oversamples SPI_CLK on the core clock, decodes the `{op[1:0], addr, turn, data}` frame, and shifts read data back on MISO.

---
 rtl/spi_pkg.sv | 31 +++
 rtl/sync_edge.sv | 39 +++
 rtl/spi_reg_target.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared widths, opcodes and FSM states for the SPI register target
//
// Purpose: frame geometry and encodings used by spi_reg_target.
// Contents: SPI_ADDR_WIDTH / SPI_DATA_WIDTH system widths, derived frame and
//           bit-counter widths, OP_WR / OP_RD opcodes, spi_state_e FSM states,
//           op_is_legal() helper.
package spi_pkg;

  localparam int SPI_ADDR_WIDTH  = 8;
  localparam int SPI_DATA_WIDTH  = 18;
  localparam int SPI_FRAME_WIDTH = SPI_ADDR_WIDTH + SPI_DATA_WIDTH + 3;
  localparam int SPI_CNT_WIDTH   = $clog2(SPI_FRAME_WIDTH);

  localparam logic [1:0] OP_WR = 2'b10;
  localparam logic [1:0] OP_RD = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OP,
    ST_ADDR,
    ST_TURN,
    ST_DATA,
    ST_DONE,
    ST_SKIP
  } spi_state_e;

  function automatic logic op_is_legal(input logic [1:0] op);
    return (op == OP_WR) || (op == OP_RD);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 2-flop synchroniser with rise/fall detect on the synchronised level
//
// Purpose: brings an asynchronous pin into the clk domain and flags its edges.
// Ports:
//   clk_i    core clock
//   rst_ni   asynchronous active-low reset
//   d_i      asynchronous input
//   rise_o   one-cycle pulse on a synchronised 0->1 transition
//   fall_o   one-cycle pulse on a synchronised 1->0 transition
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_target.sv
// rtl/spi_reg_target.sv - SPI target converting each host frame into one register write or read
//
// Purpose: oversamples SCK/CSN/MOSI on clk, decodes {op, addr, turn, data}
//          frames MSB first, issues reg_wr_en / reg_rd_en strobes and shifts
//          read data back on MISO.
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   spi_clk, spi_csn,     host SPI pins (asynchronous to clk)
//   spi_mosi
//   spi_miso, spi_miso_oe target data out and pad enable
//   reg_wr_en, reg_rd_en  one-cycle register strobes
//   reg_addr, reg_wdata   register address / write data (held after strobe)
//   reg_rdata             read data, sampled one clk after reg_rd_en
//   busy                  frame in progress (CSN fall detect to CSN rise detect)
//   frame_err             one-cycle pulse on illegal opcode or short frame
module spi_reg_target
  import spi_pkg::*;
#(
  parameter int ADDR_W = SPI_ADDR_WIDTH,
  parameter int DATA_W = SPI_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_csn,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              frame_err
);

  localparam int FRAME_W = ADDR_W + DATA_W + 3;
  localparam int CNT_W   = $clog2(FRAME_W);

  // Bit-counter values at which each field receives its final bit.
  localparam logic [CNT_W-1:0] CNT_OP_LAST   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_W + 1);
  localparam logic [CNT_W-1:0] CNT_DATA_LAST = CNT_W'(FRAME_W - 1);

  logic sck_rise, sck_fall;
  logic csn_rise, csn_fall;
  logic mosi_meta_q, mosi_s_q;

  // SCK idles low.
  sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (spi_clk),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  // CSN resets to "low" so that a CSN already low when reset releases never
  // looks like a fall; a frame only starts after CSN has been seen high.
  sync_edge #(.RST_VAL(1'b0)) u_csn_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (spi_csn),
    .rise_o (csn_rise),
    .fall_o (csn_fall)
  );

  // MOSI has the same two-flop delay as SCK, so it is aligned with sck_rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_meta_q <= 1'b0;
      mosi_s_q    <= 1'b0;
    end else begin
      mosi_meta_q <= spi_mosi;
      mosi_s_q    <= mosi_meta_q;
    end
  end

  spi_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_sr_q;
  logic [DATA_W-1:0] data_sr_q;
  logic [DATA_W-1:0] tx_sr_q;
  logic              wr_pend_q, rd_pend_q;
  logic              wr_en_q, rd_en_q;
  logic [ADDR_W-1:0] reg_addr_q;
  logic [DATA_W-1:0] reg_wdata_q;
  logic              miso_q;
  logic              busy_q;
  logic              frame_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= 2'b00;
      addr_sr_q   <= '0;
      data_sr_q   <= '0;
      tx_sr_q     <= '0;
      wr_pend_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      // Strobes are requested one cycle after the final field bit lands in
      // the shift register, then presented together with the latched values.
      wr_pend_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      wr_en_q     <= wr_pend_q;
      rd_en_q     <= rd_pend_q;
      frame_err_q <= 1'b0;

      if (wr_pend_q) begin
        reg_addr_q  <= addr_sr_q;
        reg_wdata_q <= data_sr_q;
      end
      if (rd_pend_q) begin
        reg_addr_q <= addr_sr_q;
      end
      if (rd_en_q) begin
        tx_sr_q <= reg_rdata;
      end

      if (csn_rise) begin
        if (state_q inside {ST_OP, ST_ADDR, ST_TURN, ST_DATA}) begin
          frame_err_q <= 1'b1;
        end
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        miso_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (csn_fall) begin
              state_q <= ST_OP;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          ST_OP: begin
            if (sck_rise) begin
              op_q  <= {op_q[0], mosi_s_q};
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_OP_LAST) begin
                if (op_is_legal({op_q[0], mosi_s_q})) begin
                  state_q <= ST_ADDR;
                end else begin
                  state_q     <= ST_SKIP;
                  frame_err_q <= 1'b1;
                end
              end
            end
          end
          ST_ADDR: begin
            if (sck_rise) begin
              addr_sr_q <= {addr_sr_q[ADDR_W-2:0], mosi_s_q};
              cnt_q     <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_ADDR_LAST) begin
                state_q   <= ST_TURN;
                rd_pend_q <= (op_q == OP_RD);
              end
            end
          end
          ST_TURN: begin
            if (sck_rise) begin
              cnt_q   <= cnt_q + CNT_W'(1);
              state_q <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (sck_rise) begin
              data_sr_q <= {data_sr_q[DATA_W-2:0], mosi_s_q};
              if (cnt_q == CNT_DATA_LAST) begin
                // Counter stops here, so it saturates in DONE.
                state_q   <= ST_DONE;
                wr_pend_q <= (op_q == OP_WR);
                miso_q    <= 1'b0;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
            // The first fall in DATA ends the turnaround bit and presents the
            // read data MSB; each later fall advances one bit.
            if (sck_fall && op_q == OP_RD) begin
              miso_q  <= tx_sr_q[DATA_W-1];
              tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
            end
          end
          default: begin
            // DONE / SKIP: ignore SCK until CSN rises.
          end
        endcase
      end
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = busy_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_rd_en   = rd_en_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign busy        = busy_q;
  assign frame_err   = frame_err_q;

endmodule
